add_pipe_stage: RTL and testbench
=================================

# add_pipe_stage

Two-stage pipelined add/subtract unit with valid/ready handshakes on both sides. It registers operands, computes the result with a carry-bypass adder core, and registers the sum with carry, overflow, zero and negative flags. It sits between the operand-issue logic and any result consumer (register writeback, accumulator), so the combinational carry-bypass path stays between two flop boundaries.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  stage can accept operand beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out (for subtract: 1 = no borrow)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_neg  out  1  out_sum[WIDTH-1]
- done_cnt  out  CNT_W  count of accepted output beats

## Operation
- S1 (operand register) holds s1_valid, a, b_eff = in_sub ? ~in_b : in_b, and cin = in_sub. S1 captures on in_valid && in_ready.
- S2 (result register) holds s2_valid, sum, cout, ovf, zero and neg, all computed from S1 by the adder core.
- Arithmetic: {cout, sum} = a + b_eff + cin, computed over WIDTH+1 bits; the sum wraps mod 2^WIDTH.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- s2_load = s1_valid && (!s2_valid || out_ready).
- in_ready = !rst && (!s1_valid || s2_load). This is combinational from out_ready; there is no skid buffer.
- Output handshake completes on out_valid && out_ready.
  - S2 then either reloads from S1 (if s1_valid) or clears s2_valid.
- While out_valid && !out_ready, all out_* must hold stable.
  - S1 also holds, and in_ready = !s1_valid.
- done_cnt increments on each output handshake and wraps from 2^CNT_W−1 to 0.
- Simultaneous input accept and S1→S2 transfer in the same cycle is legal. This gives full throughput of 1 op/cycle.
- Inputs with in_valid low are ignored; in_a, in_b and in_sub are don't-care.

## Timing
- Reset (rst high at a clk edge) clears:
  - s1_valid, s2_valid and done_cnt to 0
  - all data and flag registers to 0
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_neg=0
- in_ready = 0 while rst is high and 1 in the first cycle after it drops.
- Reset mid-operation discards in-flight beats in S1 and S2 with no output handshake, and done_cnt returns to 0.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, provided S2 is free.
- Back-pressure: at most two beats are held (S1 + S2). A third beat is refused (in_ready=0) until out_ready rises.
- When out_ready rises with both stages full: in that cycle S2 hands off, S1 moves to S2, and in_ready=1, so a new beat can enter S1 on the same edge.

## Structure
- Package add_pipe_pkg contains:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1
  - a packed struct add_flags_t {cout, ovf, zero, neg}
  - the default WIDTH/CNT_W localparams
- One sub-module, cba_core: combinational WIDTH-bit carry-bypass adder.
  - Built as a chain of 4-bit blocks, each with block propagate = AND of (a^b) and bypass mux for the block carry.
  - Ports: a, b, cin, sum, cout.
- The top module holds the S1/S2 registers, handshake logic, flag generation and done_cnt.

## Test plan
- Add after reset: A=0x0000_0005, B=0x0000_0003, sub=0 → two edges later, sum=0x0000_0008 with cout, ovf, zero and neg all 0; done_cnt=1 after the handshake.
- Subtract to zero and wrap:
  - 0x1234_5678 − 0x1234_5678 → sum=0, zero=1, cout=1.
  - 0x0000_0000 − 0x0000_0001 → sum=0xFFFF_FFFF, cout=0, neg=1.
- Overflow and carry:
  - 0x7FFF_FFFF + 0x0000_0001 → sum=0x8000_0000, ovf=1, neg=1, cout=0.
  - 0xFFFF_FFFF + 0x0000_0001 → sum=0, cout=1, ovf=0, zero=1.
- Back-pressure: with out_ready=0, stream 3 beats → 2 accepted, in_ready=0, outputs frozen. With out_ready=1, results emerge in order at 1/cycle and done_cnt=3.
- Streaming: 1000 random beats with in_valid and out_ready randomly toggled → every result matches a reference model in order, with no loss or duplication.
- Reset mid-flight: with both stages full, assert rst for one cycle → out_valid=0, done_cnt=0, in_ready=1 on the next cycle, and the next beat is processed normally.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared types and defaults for the two-stage add/subtract pipeline.
package add_pipe_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } add_flags_t;

endpackage

// File: rtl/add_pipe_stage_cba_core.sv
// Combinational carry-bypass adder: 4-bit ripple blocks whose carry-out is
// bypassed straight from the block carry-in when every bit propagates.
module cba_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / 4;

    logic       carry;
    logic [4:0] blk_sum;
    logic       blk_p;

    always_comb begin
        carry   = cin;
        sum     = '0;
        blk_sum = '0;
        blk_p   = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            blk_sum = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0000, carry};
            sum[4*k +: 4] = blk_sum[3:0];
            blk_p = &(a[4*k +: 4] ^ b[4*k +: 4]);
            // Full propagate: the block carry-out equals its carry-in.
            carry = blk_p ? carry : blk_sum[4];
        end
        cout = carry;
    end

endmodule

// File: rtl/add_pipe_stage.sv
// Two-stage add/subtract unit: operand register, carry-bypass adder, result
// register with flags, valid/ready on both sides and a completed-op counter.
module add_pipe_stage
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] done_cnt
);

    function automatic add_flags_t make_flags(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b_eff,
                                              input logic [WIDTH-1:0] sum,
                                              input logic             cout);
        add_flags_t f;
        f.cout = cout;
        f.ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        f.zero = (sum == '0);
        f.neg  = sum[WIDTH-1];
        return f;
    endfunction

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] a_p1_q,   a_p1_d;
    logic [WIDTH-1:0] b_p1_q,   b_p1_d;
    logic             cin_p1_q, cin_p1_d;

    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
    add_flags_t       flg_p2_q, flg_p2_d;

    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic             in_acc, s2_load, out_hs;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;

    assign s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
    assign in_ready = !rst && (!vld_p1_q || s2_load);
    assign in_acc   = in_valid && in_ready;
    assign out_hs   = vld_p2_q && out_ready;

    // Stage 1: operand capture, subtraction folded in as ~b with carry-in 1
    always_comb begin
        vld_p1_d = vld_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        cin_p1_d = cin_p1_q;
        if (in_acc) begin
            vld_p1_d = 1'b1;
            a_p1_d   = in_a;
            b_p1_d   = (in_sub == OP_SUB) ? ~in_b : in_b;
            cin_p1_d = (in_sub == OP_SUB);
        end else if (s2_load) begin
            vld_p1_d = 1'b0;
        end
    end

    cba_core #(.WIDTH(WIDTH)) u_core (
        .a    (a_p1_q),
        .b    (b_p1_q),
        .cin  (cin_p1_q),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Stage 2: result and flag register
    always_comb begin
        vld_p2_d   = vld_p2_q;
        sum_p2_d   = sum_p2_q;
        flg_p2_d   = flg_p2_q;
        done_cnt_d = done_cnt_q;
        if (s2_load) begin
            vld_p2_d = 1'b1;
            sum_p2_d = core_sum;
            flg_p2_d = make_flags(a_p1_q, b_p1_q, core_sum, core_cout);
        end else if (out_hs) begin
            vld_p2_d = 1'b0;
        end
        if (out_hs) begin
            done_cnt_d = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            a_p1_q     <= '0;
            b_p1_q     <= '0;
            cin_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            sum_p2_q   <= '0;
            flg_p2_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            a_p1_q     <= a_p1_d;
            b_p1_q     <= b_p1_d;
            cin_p1_q   <= cin_p1_d;
            vld_p2_q   <= vld_p2_d;
            sum_p2_q   <= sum_p2_d;
            flg_p2_q   <= flg_p2_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_sum   = sum_p2_q;
    assign out_cout  = flg_p2_q.cout;
    assign out_ovf   = flg_p2_q.ovf;
    assign out_zero  = flg_p2_q.zero;
    assign out_neg   = flg_p2_q.neg;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_add_pipe_stage.sv
// Bench for add_pipe_stage: directed corner cases, back-pressure, reset
// mid-flight and a random stream against a transaction-level reference model.
module tb_add_pipe_stage;

    localparam int W = 32;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;
    logic [C-1:0] done_cnt;

    always #5 clk = ~clk;

    add_pipe_stage #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .done_cnt  (done_cnt)
    );

    int            errors = 0;
    int            checks = 0;
    logic [W+3:0]  model_q[$];
    logic [C-1:0]  model_cnt = '0;
    logic          fresh = 1'b0;
    logic          stall_prev = 1'b0;
    logic [W+3:0]  held = '0;
    int            pushes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {sum, cout, ovf, zero, neg} from plain integer arithmetic.
    function automatic logic [W+3:0] ref_result(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         sub);
        logic [W:0]   wide;
        logic [W-1:0] s;
        logic         co, ov;
        if (!sub) begin
            wide = {1'b0, a} + {1'b0, b};
            s    = wide[W-1:0];
            co   = wide[W];
            ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {s, co, ov, (s == '0), s[W-1]};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = ordy;
    endtask

    // One cycle: check against the model mid-cycle, then advance past the edge.
    task automatic tick();
        logic [W+3:0] obs;
        logic [W+3:0] exp;
        int           occ;
        logic         acc;
        #3;
        obs = {out_sum, out_cout, out_ovf, out_zero, out_neg};
        occ = model_q.size();
        if (stall_prev) chk("hold", {27'd0, obs, out_valid}, {27'd0, held, 1'b1});
        chk("done_cnt", 64'(done_cnt), 64'(model_cnt));
        if (rst) begin
            chk("in_ready_rst", 64'(in_ready), 64'd0);
            model_q.delete();
            model_cnt = '0;
            fresh     = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
            chk("out_valid", 64'(out_valid), 64'((occ >= 2) || (occ == 1 && !fresh)));
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    exp = model_q.pop_front();
                    chk("result", 64'(obs), 64'(exp));
                    model_cnt = model_cnt + 1'b1;
                end
            end
            fresh = acc && (model_q.size() == 0);
            if (acc) begin
                model_q.push_back(ref_result(in_a, in_b, in_sub));
                pushes++;
            end
        end
        stall_prev = !rst && out_valid && !out_ready;
        held       = obs;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] exp_sum, input logic [3:0] exp_fl);
        drive(1'b1, a, b, sub, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        chk({tag, "_flags"}, 64'({out_cout, out_ovf, out_zero, out_neg}), 64'(exp_fl));
        tick();
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [W+3:0] frozen;
        logic [C-1:0] cnt0;
        int           cyc;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bus", 64'({out_sum, out_cout, out_ovf, out_zero, out_neg}), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed corner cases; flags are {cout, ovf, zero, neg}
        directed("add_5_3",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000);
        chk("done_after_first", 64'(done_cnt), 64'd1);
        directed("sub_zero", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b1010);
        directed("sub_wrap", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b0001);
        directed("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
        directed("add_cry",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
        directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100);

        // Back-pressure: two beats fill the pipe, the third waits
        cnt0 = done_cnt;
        drive(1'b1, 32'd100, 32'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd200, 32'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'd300, 32'd3, 1'b0, 1'b0);
        #1;
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        frozen = {out_sum, out_cout, out_ovf, out_zero, out_neg};
        tick();
        tick();
        chk("bp_frozen", 64'({out_sum, out_cout, out_ovf, out_zero, out_neg}), 64'(frozen));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("bp_done_delta", 64'(done_cnt - cnt0), 64'd3);
        chk("bp_drained", 64'(model_q.size()), 64'd0);

        // Random stream with random back-pressure
        pushes = 0;
        cyc    = 0;
        while (pushes < 1000 && cyc < 20000) begin
            drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        if (pushes < 1000) chk("rand_budget", 64'(pushes), 64'd1000);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && model_q.size() > 0; i++) tick();
        tick();
        chk("rand_drained", 64'(model_q.size()), 64'd0);
        chk("rand_out_idle", 64'(out_valid), 64'd0);

        // Reset with both stages full
        drive(1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        tick();
        chk("mid_full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        directed("post_rst", 32'h0000_0040, 32'h0000_0002, 1'b0, 32'h0000_0042, 4'b0000);
        chk("post_rst_done", 64'(done_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
